// File: rtl/mem_responder_pkg.sv
// Shared types and default widths for the mem_responder block.
package mem_responder_pkg;

  localparam int DEF_DEPTH  = 16;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 32;

  // Load side: no response held / response held on ld_data.
  typedef enum logic {
    L_IDLE = 1'b0,
    L_HOLD = 1'b1
  } ld_state_t;

  // Store side: ready for a store / completion token pending.
  typedef enum logic {
    S_IDLE = 1'b0,
    S_DONE = 1'b1
  } st_state_t;

endpackage

// File: rtl/mem_responder_ram.sv
// Register file: one combinational read port, one write port, async-reset.
// The read is combinational, so a read sampled on the same edge as a write
// sees the old word (read-before-write). Out-of-range addresses read 0 and
// writes to them are dropped.
module mem_responder_ram #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

  logic [DATA_W-1:0] mem [DEPTH];
  logic              rd_in_range;
  logic              wr_in_range;

  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_L);
  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_L);

  // Combinational read; unmapped addresses return zero.
  always_comb begin
    rd_data = '0;
    if (rd_in_range) rd_data = mem[rd_addr];
  end

  // Storage array: cleared on reset, written on an in-range store.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en && wr_in_range) begin
      mem[wr_addr] <= wr_data;
    end
  end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: small memory with independent load and store channels.
// Load: latency-1 response, one load per cycle when the response is consumed.
// Store: write at acceptance, completion token the following cycle.
// Optional macro MEM_RESPONDER_STATS_EN adds 16-bit ld_count/st_count outputs.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic              ld_addr_valid,
  output logic              ld_addr_ready,
  output logic [DATA_W-1:0] ld_data,
  output logic              ld_data_valid,
  input  logic              ld_data_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  input  logic              st_valid,
  output logic              st_ready,
  output logic              st_done_valid,
  input  logic              st_done_ready
`ifdef MEM_RESPONDER_STATS_EN
  ,
  output logic [15:0]       ld_count,
  output logic [15:0]       st_count
`endif
);

  ld_state_t         ld_state, ld_next;
  st_state_t         st_state, st_next;
  logic              ld_fire, st_fire;
  logic [DATA_W-1:0] rd_data;

  assign ld_fire = ld_addr_valid && ld_addr_ready;
  assign st_fire = st_valid && st_ready;

  mem_responder_ram #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ram (
    .clock  (clock),
    .reset  (reset),
    .rd_addr(ld_addr),
    .rd_data(rd_data),
    .wr_en  (st_fire),
    .wr_addr(st_addr),
    .wr_data(st_data)
  );

  // Load and store state registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ld_state <= L_IDLE;
      st_state <= S_IDLE;
    end else begin
      ld_state <= ld_next;
      st_state <= st_next;
    end
  end

  // Load FSM: a new load may enter whenever the held response leaves this cycle.
  always_comb begin
    ld_next       = ld_state;
    ld_data_valid = 1'b0;
    ld_addr_ready = ld_data_ready;
    case (ld_state)
      L_IDLE: begin
        ld_addr_ready = 1'b1;
        if (ld_addr_valid) ld_next = L_HOLD;
      end
      L_HOLD: begin
        ld_data_valid = 1'b1;
        if (ld_data_ready && !ld_addr_valid) ld_next = L_IDLE;
      end
      default: ld_next = L_IDLE;
    endcase
  end

  // Response register: only changes on an accepted load, so it is stable while held.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)       ld_data <= '0;
    else if (ld_fire) ld_data <= rd_data;
  end

  // Store FSM: token raised after a store, retired by st_done_ready.
  always_comb begin
    st_next       = st_state;
    st_done_valid = 1'b0;
    st_ready      = st_done_ready;
    case (st_state)
      S_IDLE: begin
        st_ready = 1'b1;
        if (st_valid) st_next = S_DONE;
      end
      S_DONE: begin
        st_done_valid = 1'b1;
        if (st_done_ready && !st_valid) st_next = S_IDLE;
      end
      default: st_next = S_IDLE;
    endcase
  end

`ifdef MEM_RESPONDER_STATS_EN
  // Accepted-transfer counters, wrapping at 16 bits.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ld_count <= '0;
      st_count <= '0;
    end else begin
      if (ld_fire) ld_count <= ld_count + 16'd1;
      if (st_fire) st_count <= st_count + 16'd1;
    end
  end
`endif

endmodule
